// File: rtl/ladybird_crossbar_rr.sv
// ladybird_crossbar_rr
//   N-core by M-peripheral bus crossbar. Each core address is decoded to one
//   peripheral from its top nibble. Each peripheral has a round-robin arbiter
//   with a zero-latency forward path, and a response FIFO that remembers which
//   core each accepted request came from. Read data is routed back to that core.
//
// Ports
//   clk, arst          clock (rising edge), asynchronous active-high reset
//   core_req/addr/wstrb/wdata   core-side request, held until core_gnt
//   core_gnt           request accepted this cycle
//   core_rdata/core_data_gnt    routed response (rdata is 0 when idle)
//   periph_req/addr/wstrb/wdata peripheral-side request (fields 0 when idle)
//   periph_gnt         peripheral accepted the presented request
//   periph_rdata/periph_data_gnt peripheral response
//   err                sticky: a response arrived with nothing outstanding
module ladybird_crossbar_rr #(
   parameter int N_CORE_BUS       = 2,
   parameter int N_PERIPHERAL_BUS = 4,
   parameter int XLEN             = 32,
   parameter logic [4*(N_PERIPHERAL_BUS-1)-1:0] ADDR_MAP = {4'hF, 4'h8, 4'h9},
   parameter int MAX_OUTSTANDING  = 4
) (
   input  logic                               clk,
   input  logic                               arst,
   input  logic [N_CORE_BUS-1:0]              core_req,
   input  logic [N_CORE_BUS*XLEN-1:0]         core_addr,
   input  logic [N_CORE_BUS*XLEN/8-1:0]       core_wstrb,
   input  logic [N_CORE_BUS*XLEN-1:0]         core_wdata,
   output logic [N_CORE_BUS-1:0]              core_gnt,
   output logic [N_CORE_BUS*XLEN-1:0]         core_rdata,
   output logic [N_CORE_BUS-1:0]              core_data_gnt,
   output logic [N_PERIPHERAL_BUS-1:0]        periph_req,
   output logic [N_PERIPHERAL_BUS*XLEN-1:0]   periph_addr,
   output logic [N_PERIPHERAL_BUS*XLEN/8-1:0] periph_wstrb,
   output logic [N_PERIPHERAL_BUS*XLEN-1:0]   periph_wdata,
   input  logic [N_PERIPHERAL_BUS-1:0]        periph_gnt,
   input  logic [N_PERIPHERAL_BUS*XLEN-1:0]   periph_rdata,
   input  logic [N_PERIPHERAL_BUS-1:0]        periph_data_gnt,
   output logic                               err
);

   localparam int NC = N_CORE_BUS;
   localparam int NP = N_PERIPHERAL_BUS;
   localparam int SW = XLEN / 8;
   localparam int CW = (NC > 1) ? $clog2(NC) : 1;
   localparam int PW = (NP > 1) ? $clog2(NP) : 1;
   localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {IDLE, LOCKED} arb_st_t;

   // per-core decode and ordering gate
   logic [PW-1:0]  tgt      [NC];
   logic [NC-1:0]  elig;
   logic [OW-1:0]  ocnt     [NC];
   logic [PW-1:0]  last_tgt [NC];

   // per-peripheral arbiter
   arb_st_t        st       [NP];
   logic [CW-1:0]  ptr      [NP];
   logic [CW-1:0]  owner    [NP];
   logic [NP-1:0]  sel_vld;
   logic [CW-1:0]  sel_core [NP];
   logic [NP-1:0]  acc;

   // per-peripheral response FIFO of core indices
   logic [CW-1:0]  fmem     [NP][MAX_OUTSTANDING];
   logic [FW-1:0]  wp       [NP];
   logic [FW-1:0]  rp       [NP];
   logic [OW-1:0]  fcnt     [NP];
   logic [NP-1:0]  fempty;
   logic [NP-1:0]  ffull;
   logic [NP-1:0]  pop;

   function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NC) s = s - NC;
      return CW'(s);
   endfunction

   function automatic logic [CW-1:0] core_inc(input logic [CW-1:0] c);
      return (int'(c) == NC - 1) ? '0 : c + CW'(1);
   endfunction

   function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] x);
      return (int'(x) == MAX_OUTSTANDING - 1) ? '0 : x + FW'(1);
   endfunction

   // Decode: ADDR_MAP is written as a list, so entry 0 is the leftmost nibble.
   // Scanning from the highest index down lets the lowest matching index win.
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         tgt[c] = PW'(NP - 1);
         for (int p = NP - 2; p >= 0; p--) begin
            if (core_addr[c*XLEN + XLEN - 4 +: 4] == ADDR_MAP[4*(NP-2-p) +: 4])
               tgt[c] = PW'(p);
         end
         // A core may only switch target once all its responses are back.
         elig[c] = core_req[c] && ((ocnt[c] == '0) || (tgt[c] == last_tgt[c]));
      end
   end

   // Arbiter selection: locked arbiters keep presenting the owner so a
   // pending un-granted request never changes.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         sel_vld[p]  = 1'b0;
         sel_core[p] = '0;
         if (st[p] == LOCKED) begin
            sel_vld[p]  = core_req[owner[p]];
            sel_core[p] = owner[p];
         end else begin
            // descending scan so the candidate closest to ptr wins
            for (int k = NC - 1; k >= 0; k--) begin
               if (elig[rr_idx(ptr[p], k)] && (tgt[rr_idx(ptr[p], k)] == PW'(p))) begin
                  sel_vld[p]  = 1'b1;
                  sel_core[p] = rr_idx(ptr[p], k);
               end
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         fempty[p] = (fcnt[p] == '0);
         ffull[p]  = (fcnt[p] == OW'(MAX_OUTSTANDING));
      end
   end

   // Forward path to the peripherals
   always_comb begin
      periph_req   = '0;
      periph_addr  = '0;
      periph_wstrb = '0;
      periph_wdata = '0;
      for (int p = 0; p < NP; p++) begin
         if (sel_vld[p] && !ffull[p] && !arst) begin
            periph_req[p]                 = 1'b1;
            periph_addr[p*XLEN +: XLEN]   = core_addr[int'(sel_core[p])*XLEN +: XLEN];
            periph_wstrb[p*SW +: SW]      = core_wstrb[int'(sel_core[p])*SW +: SW];
            periph_wdata[p*XLEN +: XLEN]  = core_wdata[int'(sel_core[p])*XLEN +: XLEN];
         end
      end
   end

   assign acc = periph_req & periph_gnt;
   // A response with nothing outstanding is dropped rather than popped.
   assign pop = periph_data_gnt & ~fempty & {NP{~arst}};

   // Grant and response routing back to the cores
   always_comb begin
      core_gnt      = '0;
      core_data_gnt = '0;
      core_rdata    = '0;
      for (int p = 0; p < NP; p++) begin
         if (acc[p])
            core_gnt[sel_core[p]] = 1'b1;
         if (pop[p]) begin
            core_data_gnt[fmem[p][rp[p]]]                   = 1'b1;
            core_rdata[int'(fmem[p][rp[p]])*XLEN +: XLEN]   = periph_rdata[p*XLEN +: XLEN];
         end
      end
   end

   // Arbiter state
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int p = 0; p < NP; p++) begin
            st[p]    <= IDLE;
            ptr[p]   <= '0;
            owner[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NP; p++) begin
            case (st[p])
               IDLE: begin
                  if (periph_req[p]) begin
                     if (periph_gnt[p]) begin
                        ptr[p] <= core_inc(sel_core[p]);
                     end else begin
                        owner[p] <= sel_core[p];
                        st[p]    <= LOCKED;
                     end
                  end
               end
               LOCKED: begin
                  if (acc[p]) begin
                     ptr[p] <= core_inc(owner[p]);
                     st[p]  <= IDLE;
                  end
               end
               default: st[p] <= IDLE;
            endcase
         end
      end
   end

   // Response FIFO storage (data only, no reset needed)
   always_ff @(posedge clk) begin
      for (int p = 0; p < NP; p++) begin
         if (acc[p])
            fmem[p][wp[p]] <= sel_core[p];
      end
   end

   // Response FIFO pointers and occupancy
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int p = 0; p < NP; p++) begin
            wp[p]   <= '0;
            rp[p]   <= '0;
            fcnt[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (acc[p]) wp[p] <= fifo_inc(wp[p]);
            if (pop[p]) rp[p] <= fifo_inc(rp[p]);
            if (acc[p] && !pop[p])
               fcnt[p] <= fcnt[p] + OW'(1);
            else if (!acc[p] && pop[p])
               fcnt[p] <= fcnt[p] - OW'(1);
         end
      end
   end

   // Per-core outstanding counters and sticky error
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int c = 0; c < NC; c++) begin
            ocnt[c]     <= '0;
            last_tgt[c] <= '0;
         end
         err <= 1'b0;
      end else begin
         for (int c = 0; c < NC; c++) begin
            if (core_gnt[c] && !core_data_gnt[c])
               ocnt[c] <= ocnt[c] + OW'(1);
            else if (!core_gnt[c] && core_data_gnt[c])
               ocnt[c] <= ocnt[c] - OW'(1);
            if (core_gnt[c])
               last_tgt[c] <= tgt[c];
         end
         if (|(periph_data_gnt & fempty))
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ladybird_crossbar_rr.sv
// Directed bench for ladybird_crossbar_rr: a cycle-by-cycle vector table
// followed by hand-written reset sequences.
module tb_ladybird_crossbar_rr;

   localparam logic [31:0] WD0 = 32'hA0A0_0000;
   localparam logic [31:0] WD1 = 32'hB1B1_0001;

   logic         clk = 1'b0;
   logic         arst;
   logic [1:0]   core_req;
   logic [63:0]  core_addr;
   logic [7:0]   core_wstrb;
   logic [63:0]  core_wdata;
   logic [1:0]   core_gnt;
   logic [63:0]  core_rdata;
   logic [1:0]   core_data_gnt;
   logic [3:0]   periph_req;
   logic [127:0] periph_addr;
   logic [15:0]  periph_wstrb;
   logic [127:0] periph_wdata;
   logic [3:0]   periph_gnt;
   logic [127:0] periph_rdata;
   logic [3:0]   periph_data_gnt;
   logic         err;

   int nvec = 0;
   int nerr = 0;

   ladybird_crossbar_rr dut (
      .clk(clk), .arst(arst),
      .core_req(core_req), .core_addr(core_addr), .core_wstrb(core_wstrb),
      .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata),
      .core_data_gnt(core_data_gnt),
      .periph_req(periph_req), .periph_addr(periph_addr), .periph_wstrb(periph_wstrb),
      .periph_wdata(periph_wdata), .periph_gnt(periph_gnt), .periph_rdata(periph_rdata),
      .periph_data_gnt(periph_data_gnt), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  req;
      logic [31:0] a0, a1;
      logic [3:0]  w0, pgnt, pdg;
      logic [31:0] rd;
      logic [3:0]  xpreq;
      logic [1:0]  xgnt, xdg;
      logic [31:0] xrd0, xrd1;
      logic        xerr;
      int          pchk;
      int          xwin;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] req, input logic [31:0] a0, a1,
                      input logic [3:0] w0, pgnt, pdg, input logic [31:0] rd,
                      input logic [3:0] xpreq, input logic [1:0] xgnt, xdg,
                      input logic [31:0] xrd0, xrd1, input logic xerr,
                      input int pchk, xwin);
      vec_t v;
      v.req = req; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.pgnt = pgnt; v.pdg = pdg;
      v.rd = rd; v.xpreq = xpreq; v.xgnt = xgnt; v.xdg = xdg; v.xrd0 = xrd0;
      v.xrd1 = xrd1; v.xerr = xerr; v.pchk = pchk; v.xwin = xwin;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act, exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic apply(input int row, input vec_t v);
      logic [31:0] ea, ed;
      logic [3:0]  ew;
      core_req        = v.req;
      core_addr       = {v.a1, v.a0};
      core_wstrb      = {4'hF, v.w0};
      periph_gnt      = v.pgnt;
      periph_data_gnt = v.pdg;
      periph_rdata    = {4{v.rd}};
      #2;
      case (v.xwin)
         0:       begin ea = v.a0; ew = v.w0; ed = WD0; end
         1:       begin ea = v.a1; ew = 4'hF; ed = WD1; end
         default: begin ea = '0;   ew = '0;   ed = '0;  end
      endcase
      chk("periph_req", row, 32'(periph_req), 32'(v.xpreq));
      chk("core_gnt", row, 32'(core_gnt), 32'(v.xgnt));
      chk("core_data_gnt", row, 32'(core_data_gnt), 32'(v.xdg));
      chk("core_rdata0", row, core_rdata[31:0], v.xrd0);
      chk("core_rdata1", row, core_rdata[63:32], v.xrd1);
      chk("err", row, 32'(err), 32'(v.xerr));
      chk("periph_addr", row, periph_addr[v.pchk*32 +: 32], ea);
      chk("periph_wstrb", row, 32'(periph_wstrb[v.pchk*4 +: 4]), 32'(ew));
      chk("periph_wdata", row, periph_wdata[v.pchk*32 +: 32], ed);
      @(posedge clk); #1;
   endtask

   initial begin
      // Single read to BLOCK_RAM, response two cycles later
      add(2'b01, 32'h9000_0010, 0, 4'h0, 4'b0100, 4'b0000, 0,            4'b0100, 2'b01, 2'b00, 0, 0, 0, 2, 0);
      add(2'b00, 0, 0, 4'h0, 4'b0000, 4'b0000, 0,                        4'b0000, 2'b00, 2'b00, 0, 0, 0, 2, -1);
      add(2'b00, 0, 0, 4'h0, 4'b0000, 4'b0100, 32'hDEAD_BEEF,            4'b0000, 2'b00, 2'b01, 32'hDEAD_BEEF, 0, 0, 2, -1);
      // Both cores on DISTRIBUTED_RAM, gnt tied high: alternate grants
      add(2'b11, 32'h8000_0004, 32'h8000_0008, 4'hF, 4'hF, 4'b0000, 0,   4'b0010, 2'b01, 2'b00, 0, 0, 0, 1, 0);
      add(2'b11, 32'h8000_0004, 32'h8000_0008, 4'hF, 4'hF, 4'b0010, 32'h1111_0004, 4'b0010, 2'b10, 2'b01, 32'h1111_0004, 0, 0, 1, 1);
      add(2'b11, 32'h8000_0004, 32'h8000_0008, 4'hF, 4'hF, 4'b0010, 32'h1111_0005, 4'b0010, 2'b01, 2'b10, 0, 32'h1111_0005, 0, 1, 0);
      add(2'b11, 32'h8000_0004, 32'h8000_0008, 4'hF, 4'hF, 4'b0010, 32'h1111_0006, 4'b0010, 2'b10, 2'b01, 32'h1111_0006, 0, 0, 1, 1);
      add(2'b11, 32'h8000_0004, 32'h8000_0008, 4'hF, 4'hF, 4'b0010, 32'h1111_0007, 4'b0010, 2'b01, 2'b10, 0, 32'h1111_0007, 0, 1, 0);
      add(2'b11, 32'h8000_0004, 32'h8000_0008, 4'hF, 4'hF, 4'b0010, 32'h1111_0008, 4'b0010, 2'b10, 2'b01, 32'h1111_0008, 0, 0, 1, 1);
      add(2'b00, 0, 0, 4'h0, 4'h0, 4'b0010, 32'h1111_0009,               4'b0000, 2'b00, 2'b10, 0, 32'h1111_0009, 0, 1, -1);
      // UART held off: core1 stays owner while core0 joins
      add(2'b10, 32'hF000_0100, 32'hF000_0000, 4'h3, 4'b0000, 4'b0000, 0, 4'b0001, 2'b00, 2'b00, 0, 0, 0, 0, 1);
      add(2'b11, 32'hF000_0100, 32'hF000_0000, 4'h3, 4'b0000, 4'b0000, 0, 4'b0001, 2'b00, 2'b00, 0, 0, 0, 0, 1);
      add(2'b11, 32'hF000_0100, 32'hF000_0000, 4'h3, 4'b0000, 4'b0000, 0, 4'b0001, 2'b00, 2'b00, 0, 0, 0, 0, 1);
      add(2'b11, 32'hF000_0100, 32'hF000_0000, 4'h3, 4'b0001, 4'b0000, 0, 4'b0001, 2'b10, 2'b00, 0, 0, 0, 0, 1);
      add(2'b01, 32'hF000_0100, 32'hF000_0000, 4'h3, 4'b0001, 4'b0000, 0, 4'b0001, 2'b01, 2'b00, 0, 0, 0, 0, 0);
      add(2'b00, 0, 0, 4'h0, 4'b0000, 4'b0001, 32'h2222_0001,            4'b0000, 2'b00, 2'b10, 0, 32'h2222_0001, 0, 0, -1);
      add(2'b00, 0, 0, 4'h0, 4'b0000, 4'b0001, 32'h2222_0002,            4'b0000, 2'b00, 2'b01, 32'h2222_0002, 0, 0, 0, -1);
      // Ordering gate: BRAM request waits for the DRAM response
      add(2'b01, 32'h0000_0100, 0, 4'h0, 4'b1000, 4'b0000, 0,            4'b1000, 2'b01, 2'b00, 0, 0, 0, 3, 0);
      add(2'b01, 32'h9000_0000, 0, 4'h0, 4'b0100, 4'b0000, 0,            4'b0000, 2'b00, 2'b00, 0, 0, 0, 2, -1);
      add(2'b01, 32'h9000_0000, 0, 4'h0, 4'b0100, 4'b0000, 0,            4'b0000, 2'b00, 2'b00, 0, 0, 0, 2, -1);
      add(2'b01, 32'h9000_0000, 0, 4'h0, 4'b0100, 4'b1000, 32'h3333_0001, 4'b0000, 2'b00, 2'b01, 32'h3333_0001, 0, 0, 2, -1);
      add(2'b01, 32'h9000_0000, 0, 4'h0, 4'b0100, 4'b0000, 0,            4'b0100, 2'b01, 2'b00, 0, 0, 0, 2, 0);
      add(2'b00, 0, 0, 4'h0, 4'b0000, 4'b0100, 32'h3333_0002,            4'b0000, 2'b00, 2'b01, 32'h3333_0002, 0, 0, 2, -1);
      // DRAM fills to MAX_OUTSTANDING, then masking and push+pop
      for (int i = 0; i < 4; i++)
         add(2'b01, 32'h0000_0200, 0, 4'h5, 4'b1000, 4'b0000, 0,         4'b1000, 2'b01, 2'b00, 0, 0, 0, 3, 0);
      add(2'b01, 32'h0000_0200, 0, 4'h5, 4'b1000, 4'b0000, 0,            4'b0000, 2'b00, 2'b00, 0, 0, 0, 3, -1);
      add(2'b01, 32'h0000_0200, 0, 4'h5, 4'b1000, 4'b1000, 32'h4444_0001, 4'b0000, 2'b00, 2'b01, 32'h4444_0001, 0, 0, 3, -1);
      add(2'b01, 32'h0000_0200, 0, 4'h5, 4'b1000, 4'b1000, 32'h4444_0002, 4'b1000, 2'b01, 2'b01, 32'h4444_0002, 0, 0, 3, 0);
      add(2'b01, 32'h0000_0200, 0, 4'h5, 4'b1000, 4'b0000, 0,            4'b1000, 2'b01, 2'b00, 0, 0, 0, 3, 0);
      add(2'b01, 32'h0000_0200, 0, 4'h5, 4'b1000, 4'b0000, 0,            4'b0000, 2'b00, 2'b00, 0, 0, 0, 3, -1);
      for (int i = 3; i < 7; i++)
         add(2'b00, 0, 0, 4'h0, 4'b0000, 4'b1000, 32'h4444_0000 + 32'(i), 4'b0000, 2'b00, 2'b01, 32'h4444_0000 + 32'(i), 0, 0, 3, -1);
      // Response with an empty FIFO: dropped, err latches next edge
      add(2'b00, 0, 0, 4'h0, 4'b0000, 4'b0010, 32'h5555_5555,            4'b0000, 2'b00, 2'b00, 0, 0, 0, 1, -1);
      add(2'b00, 0, 0, 4'h0, 4'b0000, 4'b0000, 0,                        4'b0000, 2'b00, 2'b00, 0, 0, 1, 1, -1);

      // Outputs stay quiet while reset is held, even with live inputs
      arst            = 1'b1;
      core_req        = 2'b11;
      core_addr       = {32'h8000_0008, 32'h9000_0000};
      core_wstrb      = 8'hFF;
      core_wdata      = {WD1, WD0};
      periph_gnt      = 4'hF;
      periph_data_gnt = 4'hF;
      periph_rdata    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_periph_req", -1, 32'(periph_req), 32'h0);
      chk("rst_core_gnt", -1, 32'(core_gnt), 32'h0);
      chk("rst_core_data_gnt", -1, 32'(core_data_gnt), 32'h0);
      chk("rst_err", -1, 32'(err), 32'h0);
      core_req        = '0;
      periph_gnt      = '0;
      periph_data_gnt = '0;
      arst            = 1'b0;

      foreach (vecs[i]) apply(i, vecs[i]);

      // Reset in the middle of a burst
      core_req   = 2'b11;
      core_addr  = {32'h8000_0008, 32'h8000_0004};
      core_wstrb = 8'hFF;
      periph_gnt = 4'b0010;
      #2;
      chk("burst_preq", 100, 32'(periph_req), 32'h2);
      chk("burst_gnt0", 100, 32'(core_gnt), 32'h1);
      chk("err_sticky", 100, 32'(err), 32'h1);
      @(posedge clk); #1;
      #2;
      chk("burst_gnt1", 101, 32'(core_gnt), 32'h2);
      #1;
      arst            = 1'b1;
      periph_data_gnt = 4'b0010;
      #1;
      chk("arst_preq", 102, 32'(periph_req), 32'h0);
      chk("arst_gnt", 102, 32'(core_gnt), 32'h0);
      chk("arst_dg", 102, 32'(core_data_gnt), 32'h0);
      chk("arst_rdata", 102, core_rdata[31:0] | core_rdata[63:32], 32'h0);
      chk("arst_err", 102, 32'(err), 32'h0);
      @(posedge clk); #1;
      // After release: ptr back to 0 and counters cleared, so core0 may
      // move straight to BLOCK_RAM while core1 wins DISTRIBUTED_RAM.
      arst            = 1'b0;
      periph_data_gnt = '0;
      core_addr       = {32'h8000_0008, 32'h9000_0000};
      periph_gnt      = 4'b0110;
      #2;
      chk("rel_preq", 103, 32'(periph_req), 32'h6);
      chk("rel_gnt", 103, 32'(core_gnt), 32'h3);
      chk("rel_addr1", 103, periph_addr[63:32], 32'h8000_0008);
      @(posedge clk); #1;
      core_req   = '0;
      periph_gnt = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rel_err", 104, 32'(err), 32'h0);
      chk("rel_idle_preq", 104, 32'(periph_req), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      arst            = 1'b1;
      core_req        = '0;
      core_addr       = '0;
      core_wstrb      = '0;
      core_wdata      = {WD1, WD0};
      periph_gnt      = '0;
      periph_rdata    = '0;
      periph_data_gnt = '0;
   end

endmodule
